// File: rtl/led_matrix_pkg.sv
// Shared definitions for the 5x7 LED matrix: geometry, scan states and
// helpers that turn a column index and frame image into pin-level drive.
package led_matrix_pkg;

    localparam int NUM_COLUMNS = 5;
    localparam int NUM_ROWS    = 7;
    localparam int IMAGE_WIDTH = NUM_COLUMNS * NUM_ROWS;
    localparam int IDX_WIDTH   = $clog2(NUM_COLUMNS);

    typedef logic [NUM_COLUMNS-1:0] column_bits_t;
    typedef logic [NUM_ROWS-1:0]    row_bits_t;
    typedef logic [IMAGE_WIDTH-1:0] image_t;
    typedef logic [IDX_WIDTH-1:0]   column_idx_t;

    localparam column_idx_t  FIRST_COLUMN = '0;
    localparam column_idx_t  LAST_COLUMN  = column_idx_t'(NUM_COLUMNS - 1);
    localparam column_bits_t COLUMNS_OFF  = '0;
    // Rows are active-low, so all-ones turns every LED off.
    localparam row_bits_t    ROWS_OFF     = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BLANK = 2'b01,
        ST_DRIVE = 2'b10
    } scan_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One-hot column select for the given index; all zero for an out-of-range index.
    function automatic column_bits_t column_onehot(input column_idx_t idx);
        column_bits_t sel;
        sel = '0;
        for (int c = 0; c < NUM_COLUMNS; c++) begin
            if (idx == column_idx_t'(c)) sel[c] = 1'b1;
        end
        return sel;
    endfunction

    // Active-low row drive for one column of the image (bit 7*c+r is row r of column c).
    function automatic row_bits_t column_rows(input image_t image, input column_idx_t idx);
        row_bits_t lit;
        lit = '0;
        for (int c = 0; c < NUM_COLUMNS; c++) begin
            if (idx == column_idx_t'(c)) lit = image[c*NUM_ROWS +: NUM_ROWS];
        end
        return ~lit;
    endfunction

endpackage : led_matrix_pkg

// File: rtl/led_matrix_tick_counter.sv
// Loadable down-counter timing the blank and dwell phases. It saturates at
// zero, where the terminal flag is raised, so it can never wrap.
module led_matrix_tick_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             terminal
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load wins, otherwise step down and hold at zero.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign terminal = (count_q == '0);

endmodule : led_matrix_tick_counter

// File: rtl/led_matrix_scanner.sv
// Column-multiplexed scanner for a 5x7 LED matrix. Each column is preceded by
// a blank gap (anti-ghosting) and then driven for a fixed dwell. The image is
// captured once per frame so a changing input never tears a displayed frame.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 5000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [IMAGE_WIDTH-1:0] rows_status,
    output logic [NUM_COLUMNS-1:0] columns,
    output logic [NUM_ROWS-1:0]    rows,
    output logic                   frame_done
);

    localparam int CNT_MAX   = max_int(DWELL_CYCLES, BLANK_CYCLES);
    localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

    // The counter runs from N-1 down to 0, so a phase lasts exactly N cycles.
    localparam logic [CNT_WIDTH-1:0] BLANK_LOAD = CNT_WIDTH'(BLANK_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DWELL_LOAD = CNT_WIDTH'(DWELL_CYCLES - 1);

    scan_state_e  state_q, state_d;
    column_idx_t  idx_q, idx_d;
    image_t       frame_q, frame_d;
    column_bits_t columns_q, columns_d;
    row_bits_t    rows_q, rows_d;
    logic         frame_done_q, frame_done_d;

    logic                 cnt_load;
    logic [CNT_WIDTH-1:0] cnt_load_value;
    logic                 cnt_terminal;

    led_matrix_tick_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_tick_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .terminal   (cnt_terminal)
    );

    // Next state, column index, frame capture and counter reloads.
    // Dropping enable takes priority over any phase end, so a frame cut
    // short never reports completion and never re-latches.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        frame_d        = frame_q;
        frame_done_d   = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_value = BLANK_LOAD;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    frame_d        = rows_status;
                    idx_d          = FIRST_COLUMN;
                    state_d        = ST_BLANK;
                    cnt_load       = 1'b1;
                    cnt_load_value = BLANK_LOAD;
                end
            end

            ST_BLANK: begin
                if (!enable) begin
                    state_d        = ST_IDLE;
                    idx_d          = FIRST_COLUMN;
                    cnt_load       = 1'b1;
                    cnt_load_value = '0;
                end else if (cnt_terminal) begin
                    state_d        = ST_DRIVE;
                    cnt_load       = 1'b1;
                    cnt_load_value = DWELL_LOAD;
                end
            end

            ST_DRIVE: begin
                if (!enable) begin
                    state_d        = ST_IDLE;
                    idx_d          = FIRST_COLUMN;
                    cnt_load       = 1'b1;
                    cnt_load_value = '0;
                end else if (cnt_terminal) begin
                    if (idx_q == LAST_COLUMN) begin
                        idx_d        = FIRST_COLUMN;
                        frame_done_d = 1'b1;
                        frame_d      = rows_status;
                    end else begin
                        idx_d = idx_q + column_idx_t'(1);
                    end
                    state_d        = ST_BLANK;
                    cnt_load       = 1'b1;
                    cnt_load_value = BLANK_LOAD;
                end
            end

            default: begin
                state_d        = ST_IDLE;
                idx_d          = FIRST_COLUMN;
                cnt_load       = 1'b1;
                cnt_load_value = '0;
            end
        endcase
    end

    // Output drive derived from the next state, so the registered pins
    // always agree with the state register in the same cycle.
    always_comb begin
        columns_d = COLUMNS_OFF;
        rows_d    = ROWS_OFF;
        if (state_d == ST_DRIVE) begin
            columns_d = column_onehot(idx_d);
            rows_d    = column_rows(frame_d, idx_d);
        end
    end

    // State, index, frame buffer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= FIRST_COLUMN;
            // NOTE: the frame buffer is reset too, so nothing left from before reset can ever be displayed.
            frame_q      <= '0;
            columns_q    <= COLUMNS_OFF;
            rows_q       <= ROWS_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            columns_q    <= columns_d;
            rows_q       <= rows_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign columns    = columns_q;
    assign rows       = rows_q;
    assign frame_done = frame_done_q;

endmodule : led_matrix_scanner

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with a short dwell/blank so whole
// frames fit in a few dozen cycles. Expected pin values come from a cycle
// position model: cycle k after enable is sampled is blank or drives a column.
module tb_led_matrix_scanner;

    localparam int TB_DWELL  = 4;
    localparam int TB_BLANK  = 1;
    localparam int COL_SLOT  = TB_BLANK + TB_DWELL;
    localparam int FRAME_LEN = 5 * COL_SLOT;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [34:0] rows_status;
    logic [4:0]  columns;
    logic [6:0]  rows;
    logic        frame_done;

    int checks;
    int errors;
    int pulse_count;

    led_matrix_scanner #(
        .DWELL_CYCLES (TB_DWELL),
        .BLANK_CYCLES (TB_BLANK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rows_status (rows_status),
        .columns     (columns),
        .rows        (rows),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_blank(input string tag);
        check({tag, " columns"}, 64'(columns), 64'h00);
        check({tag, " rows"}, 64'(rows), 64'h7F);
        check({tag, " frame_done"}, 64'(frame_done), 64'h0);
    endtask

    // Called at a negedge with the block in IDLE: raise enable, then check
    // ncyc following negedges against the position model. Frame 0 shows
    // img_first, later frames img_next; rows_status becomes change_val right
    // after the sample of cycle change_k.
    task automatic start_and_scan(input int ncyc, input logic [34:0] img_first,
                                  input logic [34:0] img_next, input int change_k,
                                  input logic [34:0] change_val);
        logic [34:0] img;
        logic [4:0]  exp_cols;
        logic [6:0]  exp_rows;
        logic        exp_done;
        int          p, f, c, ph;
        enable = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            p   = (k - 1) % FRAME_LEN;
            f   = (k - 1) / FRAME_LEN;
            c   = p / COL_SLOT;
            ph  = p % COL_SLOT;
            img = (f == 0) ? img_first : img_next;
            if (ph < TB_BLANK) begin
                exp_cols = 5'b00000;
                exp_rows = 7'h7F;
            end else begin
                exp_cols = 5'b00001 << c;
                exp_rows = ~img[c*7 +: 7];
            end
            exp_done = (k > 1) && (p == 0);
            check($sformatf("k%0d columns", k), 64'(columns), 64'(exp_cols));
            check($sformatf("k%0d rows", k), 64'(rows), 64'(exp_rows));
            check($sformatf("k%0d frame_done", k), 64'(frame_done), 64'(exp_done));
            if (frame_done === 1'b1) pulse_count++;
            if (k == change_k) rows_status = change_val;
        end
    endtask

    logic [34:0] img_a;
    logic [34:0] img_c;
    logic [34:0] img_d;

    initial begin
        checks      = 0;
        errors      = 0;
        pulse_count = 0;
        rst_n       = 1'b0;
        enable      = 1'b0;
        rows_status = '0;
        img_a = {7'h01, 7'h70, 7'h33, 7'h0F, 7'h55};
        img_c = {7'h11, 7'h22, 7'h44, 7'h08, 7'h7E};
        img_d = {7'h6B, 7'h35, 7'h1A, 7'h4D, 7'h26};

        // Reset state, then idle with enable low.
        repeat (3) @(negedge clk);
        check_blank("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_blank("idle");

        // First column timing, full frames and frame_done cadence.
        rows_status = img_a;
        pulse_count = 0;
        start_and_scan(101, img_a, img_a, -1, '0);
        check("frame_done pulses", 64'(pulse_count), 64'd4);
        enable = 1'b0;
        @(negedge clk);
        check_blank("stop after frames");

        // No tearing: image switches to all-ones during column 2.
        rows_status = '0;
        @(negedge clk);
        start_and_scan(31, 35'h0, {35{1'b1}}, 12, {35{1'b1}});
        enable = 1'b0;
        @(negedge clk);
        check_blank("stop after tearing run");

        // Enable dropped during column 3 drive, then re-enable from column 0.
        rows_status = img_a;
        @(negedge clk);
        start_and_scan(18, img_a, img_a, -1, '0);
        enable = 1'b0;
        rows_status = img_c;
        @(negedge clk);
        check_blank("drop in col3");
        @(negedge clk);
        check_blank("idle after drop");
        start_and_scan(7, img_c, img_c, -1, '0);
        enable = 1'b0;
        @(negedge clk);
        check_blank("stop after restart");

        // Enable dropped exactly at column 4 dwell end: no frame_done.
        rows_status = img_d;
        @(negedge clk);
        pulse_count = 0;
        start_and_scan(25, img_d, img_d, -1, '0);
        enable = 1'b0;
        rows_status = img_a;
        @(negedge clk);
        check_blank("drop at col4 end");
        @(negedge clk);
        check_blank("idle after col4 drop");
        check("no pulse on col4 drop", 64'(pulse_count), 64'd0);

        // Asynchronous reset mid-drive, then restart straight out of reset.
        rows_status = img_c;
        @(negedge clk);
        start_and_scan(3, img_c, img_c, -1, '0);
        check("pre-reset column", 64'(columns), 64'h01);
        #1 rst_n = 1'b0;
        #1;
        check_blank("async reset");
        @(negedge clk);
        check_blank("held in reset");
        rows_status = img_d;
        rst_n = 1'b1;
        start_and_scan(6, img_d, img_d, -1, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_led_matrix_scanner
